mem_port_ctrl: RTL
==================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, width of the main-memory byte address.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  load/store request from the LSQ present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_wr  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, low bytes used.
REQ-011 req_rd / req_rob / req_pc  input  6/6/12  physical dest tag, ROB index, PC; carried to the response.
REQ-012 mem_cs, mem_re, mem_wr  output  1 each  single-port memory chip select, read strobe, write strobe.
REQ-013 mem_address  output  ADDR_WIDTH  memory byte address.
REQ-014 mem_wdata  output  8  byte written.
REQ-015 mem_rdata  input  8  byte read; valid the cycle after the mem_re cycle.
REQ-016 resp_valid  output  1  one-cycle completion pulse for result bus 2.
REQ-017 resp_data / resp_rd / resp_rob / resp_pc / resp_wr  output  32/6/6/12/1  load result (0 for stores) and carried fields.

Function
REQ-018 FSM states: IDLE, ACCESS, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-019 Acceptance occurs in the cycle with req_valid && req_ready (cycle 0); all request fields latch at its closing edge; IDLE -> ACCESS.
REQ-020 N = 1/2/4 bytes for byte/half/word; byte k uses address (req_addr + k) mod 2^ADDR_WIDTH, little-endian; misalignment is permitted.
REQ-021 ACCESS lasts N cycles; in cycle k (1..N), mem_cs = 1, mem_address = byte k-1, and either mem_re = 1 (load) or mem_wr = 1 with mem_wdata = req_wdata byte k-1 (store).
REQ-022 A load captures mem_rdata in cycle k+1 into result byte k-1.
REQ-023 After ACCESS, a store moves to RESP, so resp_valid is in cycle N+1; a load moves to WAIT for one cycle, then RESP, so resp_valid is in cycle N+2.
REQ-024 Load result is extended from bit 8N-1 per req_unsigned.
REQ-025 RESP lasts exactly one cycle and has no backpressure; then the FSM returns to IDLE, so the earliest next acceptance is the cycle after resp_valid.
REQ-026 Outside ACCESS, mem_cs = mem_re = mem_wr = 0 and mem_address and mem_wdata hold 0.
REQ-027 resp_* fields are 0 whenever resp_valid = 0.
REQ-028 Address wrap: the byte after 2^ADDR_WIDTH-1 is address 0.

Reset
REQ-029 rst low immediately forces IDLE and drives every output to 0 except req_ready, which is 1.
REQ-030 An in-flight request is dropped with no response and no further memory strobe; any bytes already written stay written.
REQ-031 The first acceptance is possible in the first cycle with rst high.

Configuration
REQ-032 With macro MEM_PORT_CTRL_ERR_EN defined, the block adds an output resp_err (1 bit). An accepted request with req_addr[31:ADDR_WIDTH] != 0 skips ACCESS and WAIT, goes directly to RESP in cycle 1, and returns resp_err = 1 and resp_data = 0.
REQ-033 Without MEM_PORT_CTRL_ERR_EN, port resp_err does not exist and the upper address bits are ignored, so the address is truncated.

Verification
REQ-034 Store word 0xDEADBEEF to 0x00100 -> cycles 1-4 mem_wr with bytes EF, BE, AD, DE at 0x100-0x103; resp_valid in cycle 5, resp_data 0.
REQ-035 Memory 0x200 = 0x80; signed byte load -> resp_data 0xFFFFFF80 in cycle 3. Same load unsigned -> 0x00000080.
REQ-036 Half load at 0xFFFFF with mem[0xFFFFF] = 0x34 and mem[0x00000] = 0x12 -> addresses 0xFFFFF then 0x00000; resp_data 0x00001234 in cycle 4.
REQ-037 Drop rst low in cycle 2 of a word store -> all strobes 0 immediately; no resp_valid; req_ready = 1.
REQ-038 Hold req_valid high continuously with back-to-back byte loads -> req_ready is 0 from cycle 1 through RESP; second acceptance occurs the cycle after the first resp_valid, and the first response carries the first request's rd, rob and pc.
REQ-039 With MEM_PORT_CTRL_ERR_EN, load at 0x00100000 -> no mem_cs; resp_valid with resp_err = 1 in cycle 1.

Source files
------------

// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: LSQ request/response and byte-memory signals for mem_port_ctrl.
// resp_err exists only when MEM_PORT_CTRL_ERR_EN is defined.
interface mem_port_ctrl_if #(parameter int ADDR_WIDTH = 20) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [5:0]            req_rd;
  logic [5:0]            req_rob;
  logic [11:0]           req_pc;
  logic                  mem_cs;
  logic                  mem_re;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  resp_valid;
  logic [31:0]           resp_data;
  logic [5:0]            resp_rd;
  logic [5:0]            resp_rob;
  logic [11:0]           resp_pc;
  logic                  resp_wr;
`ifdef MEM_PORT_CTRL_ERR_EN
  logic                  resp_err;
  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, req_rd, req_rob, req_pc, mem_rdata,
    output req_ready, mem_cs, mem_re, mem_wr, mem_address, mem_wdata,
    output resp_valid, resp_data, resp_rd, resp_rob, resp_pc, resp_wr, resp_err
  );
  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, req_rd, req_rob, req_pc, mem_rdata,
    input  req_ready, mem_cs, mem_re, mem_wr, mem_address, mem_wdata,
    input  resp_valid, resp_data, resp_rd, resp_rob, resp_pc, resp_wr, resp_err
  );
`else
  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, req_rd, req_rob, req_pc, mem_rdata,
    output req_ready, mem_cs, mem_re, mem_wr, mem_address, mem_wdata,
    output resp_valid, resp_data, resp_rd, resp_rob, resp_pc, resp_wr
  );
  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, req_rd, req_rob, req_pc, mem_rdata,
    input  req_ready, mem_cs, mem_re, mem_wr, mem_address, mem_wdata,
    input  resp_valid, resp_data, resp_rd, resp_rob, resp_pc, resp_wr
  );
`endif
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: byte-serial load/store port between the LSQ and a single-port 8-bit memory.
// Define MEM_PORT_CTRL_ERR_EN to reject out-of-range addresses with resp_err instead of truncating.
module mem_port_ctrl #(parameter int ADDR_WIDTH = 20) (
  input logic           clk,
  input logic           rst,
  mem_port_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t                r_state, w_next;
  logic                  r_wr, r_uns, r_cap, r_err;
  logic [1:0]            r_size, r_cnt, r_prev, w_last_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, r_data, w_ext;
  logic [5:0]            r_rd, r_rob;
  logic [11:0]           r_pc;
  logic                  w_acc, w_bad, w_last, w_mem, w_resp;
  assign w_acc = bus.req_valid && r_state == IDLE;
`ifdef MEM_PORT_CTRL_ERR_EN
  assign w_bad = |(bus.req_addr >> ADDR_WIDTH);
`else
  assign w_bad = 1'b0;
`endif
  assign w_last_idx = r_size == 2'b00 ? 2'd0 : r_size == 2'b01 ? 2'd1 : 2'd3;
  assign w_last = r_cnt == w_last_idx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = w_bad ? RESP : ACCESS;
      ACCESS:  if (w_last) w_next = r_wr ? RESP : WAIT;
      WAIT:    w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // Read data lags its strobe by one cycle, so capture uses the previous cycle's byte index.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr    <= 1'b0;
      r_uns   <= 1'b0;
      r_cap   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_cnt   <= 2'b00;
      r_prev  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_rd    <= '0;
      r_rob   <= '0;
      r_pc    <= '0;
    end else begin
      r_cap  <= r_state == ACCESS && !r_wr;
      r_prev <= r_cnt;
      if (r_cap) r_data[{r_prev, 3'b000} +: 8] <= bus.mem_rdata;
      if (w_acc) begin
        r_wr    <= bus.req_wr;
        r_uns   <= bus.req_unsigned;
        r_size  <= bus.req_size;
        r_addr  <= bus.req_addr[ADDR_WIDTH-1:0];
        r_wdata <= bus.req_wdata;
        r_rd    <= bus.req_rd;
        r_rob   <= bus.req_rob;
        r_pc    <= bus.req_pc;
        r_err   <= w_bad;
        r_cnt   <= 2'b00;
        r_data  <= '0;
      end else if (r_state == ACCESS) r_cnt <= r_cnt + 2'd1;
    end
  assign w_ext = r_size == 2'b00 ? {{24{!r_uns && r_data[7]}}, r_data[7:0]} :
                 r_size == 2'b01 ? {{16{!r_uns && r_data[15]}}, r_data[15:0]} : r_data;
  assign w_mem  = r_state == ACCESS;
  assign w_resp = r_state == RESP;
  assign bus.req_ready   = r_state == IDLE;
  assign bus.mem_cs      = w_mem;
  assign bus.mem_re      = w_mem && !r_wr;
  assign bus.mem_wr      = w_mem && r_wr;
  assign bus.mem_address = w_mem ? r_addr + ADDR_WIDTH'(r_cnt) : '0;
  assign bus.mem_wdata   = w_mem && r_wr ? r_wdata[{r_cnt, 3'b000} +: 8] : '0;
  assign bus.resp_valid  = w_resp;
  assign bus.resp_data   = w_resp && !r_wr && !r_err ? w_ext : '0;
  assign bus.resp_rd     = w_resp ? r_rd : '0;
  assign bus.resp_rob    = w_resp ? r_rob : '0;
  assign bus.resp_pc     = w_resp ? r_pc : '0;
  assign bus.resp_wr     = w_resp && r_wr;
`ifdef MEM_PORT_CTRL_ERR_EN
  assign bus.resp_err    = w_resp && r_err;
`endif
endmodule
